// File: rtl/mby_gmm_pkg.sv
// ============================================================================
//  Package     : mby_gmm_pkg
//  Description : Shared types and defaults for the GMM north dequeue arbiter.
//                Defines the dequeue payload record, default sizing for the
//                arbiter, and the width of the per-requester grant counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mby_gmm_pkg;

    // Dequeue payload as carried on the mby_deque_from_vp stream.
    typedef struct packed {
        logic [3:0]  vp;    // egress virtual-port partition id
        logic [11:0] qid;   // queue identifier to dequeue from
    } mby_deque_t;

    localparam int MBY_DEQUE_W           = $bits(mby_deque_t);
    localparam int MBY_GMM_DQ_NUM_REQ    = 4;
    localparam int MBY_GMM_DQ_FIFO_DEPTH = 4;
    localparam int MBY_GMM_DQ_GCNT_W     = 16;

endpackage

`default_nettype wire

// File: rtl/mby_gmm_dq_fifo.sv
// ============================================================================
//  Module      : mby_gmm_dq_fifo
//  Description : Small synchronous FIFO buffering one requester's dequeues.
//                Read data is the current head (show-ahead). The caller must
//                only push when not full and only pop when not empty.
//  Ports       : cclk, reset_n        clock / async active-low reset
//                push, wdata          write strobe and data
//                pop, rdata           read strobe and head-of-queue data
//                full, empty, count   occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mby_gmm_dq_fifo
    import mby_gmm_pkg::*;
#(
    parameter  int DEPTH = MBY_GMM_DQ_FIFO_DEPTH,
    parameter  int WIDTH = MBY_DEQUE_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             cclk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries no reset: contents are only observed when count != 0.
    always_ff @(posedge cclk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/mby_gmm_deque_arb.sv
// ============================================================================
//  Module      : mby_gmm_deque_arb
//  Description : Dequeue arbiter in front of the GMM north dequeue port.
//                Buffers requests per partition, grants round-robin onto one
//                registered output stream, and holds grants off during pod
//                ring stall.
//  Ports       : cclk, reset_n          clock / async active-low reset
//                req_valid/deque/ready  per-partition request handshake
//                pod_ring_stall_in      blocks new grants while high
//                deque_valid, mby_deque_from_vp  registered granted dequeue
//                ovf_err                sticky push-while-full flags
//                grant_cnt              saturating per-partition grant counts
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mby_gmm_deque_arb
    import mby_gmm_pkg::*;
#(
    parameter int NUM_REQ    = MBY_GMM_DQ_NUM_REQ,
    parameter int FIFO_DEPTH = MBY_GMM_DQ_FIFO_DEPTH
) (
    input  logic                                        cclk,
    input  logic                                        reset_n,
    input  logic       [NUM_REQ-1:0]                    req_valid,
    input  mby_deque_t [NUM_REQ-1:0]                    req_deque,
    output logic       [NUM_REQ-1:0]                    req_ready,
    input  logic                                        pod_ring_stall_in,
    output logic                                        deque_valid,
    output mby_deque_t                                  mby_deque_from_vp,
    output logic       [NUM_REQ-1:0]                    ovf_err,
    output logic       [NUM_REQ-1:0][MBY_GMM_DQ_GCNT_W-1:0] grant_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]     push;
    logic [NUM_REQ-1:0]     pop;
    logic [NUM_REQ-1:0]     full;
    logic [NUM_REQ-1:0]     empty;
    logic [NUM_REQ-1:0]     eligible;
    logic [CW-1:0]          count [NUM_REQ];
    logic [MBY_DEQUE_W-1:0] head  [NUM_REQ];

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_next;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     rot;
    logic [PTR_W-1:0]       off;
    logic [SUM_W-1:0]       sum;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            // Ready looks only at the registered count, so a push arriving in
            // the same cycle as a pop of a full FIFO is still refused.
            assign req_ready[i] = (count[i] != CW'(FIFO_DEPTH));
            assign push[i]      = req_valid[i] & req_ready[i];
            assign pop[i]       = grant_any & (grant_idx == PTR_W'(i));
            assign eligible[i]  = ~empty[i];

            mby_gmm_dq_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (MBY_DEQUE_W)
            ) u_fifo (
                .cclk    (cclk),
                .reset_n (reset_n),
                .push    (push[i]),
                .wdata   (req_deque[i]),
                .pop     (pop[i]),
                .rdata   (head[i]),
                .full    (full[i]),
                .empty   (empty[i]),
                .count   (count[i])
            );
        end
    endgenerate

    // Round-robin: rotate a doubled eligibility vector so rr_ptr sits at bit
    // 0, take the lowest set bit, then map the offset back to an index.
    always_comb begin
        dbl       = {eligible, eligible};
        rot       = NUM_REQ'(dbl >> rr_ptr);
        grant_any = 1'b0;
        off       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_any = 1'b1;
                off       = PTR_W'(k);
            end
        end
        grant_any = grant_any & ~pod_ring_stall_in;
        sum       = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        grant_idx = sum[PTR_W-1:0];
        rr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr            <= '0;
            deque_valid       <= 1'b0;
            mby_deque_from_vp <= '0;
            ovf_err           <= '0;
            grant_cnt         <= '0;
        end else begin
            deque_valid <= grant_any;
            if (grant_any) begin
                rr_ptr            <= rr_next;
                mby_deque_from_vp <= mby_deque_t'(head[grant_idx]);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && full[i]) begin
                    ovf_err[i] <= 1'b1;
                end
                if (pop[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
